gorev_birimi_cekirdek: RTL and testbench

GOREV_BIRIMI_CEKIRDEK -- requirements
Module: gorev_birimi

---
 rtl/gorev_birimi_cekirdek.sv | 178 +++++++++++++++++
 tb/tb_gorev_birimi_cekirdek.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gorev_birimi_cekirdek.sv
// gorev_birimi_cekirdek: streaming 3x3 neighbourhood engine (passthrough, Sobel |Gx|/|Gy|/sum, optional blur).
// Defining GORB_BULANIK_EN builds the Gaussian blur datapath for task code 3'd4.
module gorev_birimi_cekirdek #(
  parameter int GENISLIK  = 320,
  parameter int YUKSEKLIK = 240
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       basla,
  input  logic       etkin_i,
  input  logic [7:0] pixel_i,
  input  logic [2:0] gorev_i,
  output logic       etkin_o,
  output logic [7:0] pixel_o,
  output logic [1:0] durum_o
);
  // Valid-only stream, no backpressure: a pixel is taken on each rising edge where etkin_i is high
  // inside a running frame; etkin_o is a registered one-cycle strobe qualifying pixel_o.
  localparam logic [2:0] GRV1_GECIR   = 3'd0;
  localparam logic [2:0] GRV1_G_SX    = 3'd1;
  localparam logic [2:0] GRV1_G_SY    = 3'd2;
  localparam logic [2:0] GRV1_G_SXY   = 3'd3;
  localparam logic [2:0] GRV1_BULANIK = 3'd4;

  localparam int CW = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
  localparam int RW = $clog2(YUKSEKLIK + 2);
  localparam logic [CW-1:0] SON_SUTUN = CW'(GENISLIK - 1);
  localparam logic [RW-1:0] SON_SATIR = RW'(YUKSEKLIK - 1);
  localparam logic [RW-1:0] SATIR_H   = RW'(YUKSEKLIK);
  localparam logic [RW-1:0] SATIR_H1  = RW'(YUKSEKLIK + 1);

  typedef enum logic [1:0] {BOS = 2'd0, CALIS = 2'd1, BOSALT = 2'd2} durum_t;

  durum_t        durum_q, durum_d;
  logic [RW-1:0] satir_q, satir_d;
  logic [CW-1:0] sutun_q, sutun_d;
  logic [2:0]    gorev_q, gorev_d;
  logic          etkin_q, etkin_d;
  logic [7:0]    pixel_q, pixel_d;

  logic [7:0] hat0 [GENISLIK];
  logic [7:0] hat1 [GENISLIK];
  logic [7:0] pen_q [3][3];

  logic        kabul, sutun0, kuzey_yok, guney_yok, bati_yok, dogu_yok, cikis_var;
  logic [7:0]  giris;
  logic [7:0]  yeni [3];
  logic        satir_sil [3];
  logic [7:0]  kom [3][3];
  logic [11:0] gx, gy, ax, ay, axy;
  logic [7:0]  sonuc;
`ifdef GORB_BULANIK_EN
  logic [11:0] bul;
`endif

  function automatic logic [7:0] doyur(input logic [11:0] v);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction

  always_comb begin
    kabul   = !basla && ((durum_q == CALIS && etkin_i) || durum_q == BOSALT);
    giris   = (durum_q == CALIS) ? pixel_i : 8'd0;
    sutun0  = (sutun_q == '0);
    yeni[0] = hat0[sutun_q];
    yeni[1] = hat1[sutun_q];
    yeni[2] = giris;
    // Centre trails the input by one row and one column; at input column 0 it is
    // the last column of the row two above, so its east neighbour is padding.
    kuzey_yok = sutun0 ? (satir_q == RW'(2)) : (satir_q == RW'(1));
    guney_yok = sutun0 ? (satir_q == SATIR_H1) : (satir_q == SATIR_H);
    bati_yok  = (sutun_q == CW'(1));
    dogu_yok  = sutun0;
    cikis_var = (satir_q >= RW'(2)) || (satir_q == RW'(1) && !sutun0);
    satir_sil[0] = kuzey_yok;
    satir_sil[1] = 1'b0;
    satir_sil[2] = guney_yok;
    for (int r = 0; r < 3; r++) begin
      kom[r][0] = (satir_sil[r] || bati_yok) ? 8'd0 : pen_q[r][1];
      kom[r][1] = satir_sil[r] ? 8'd0 : pen_q[r][2];
      kom[r][2] = (satir_sil[r] || dogu_yok) ? 8'd0 : yeni[r];
    end
  end

  always_comb begin
    gx  = (12'(kom[0][2]) + {3'd0, kom[1][2], 1'b0} + 12'(kom[2][2]))
        - (12'(kom[0][0]) + {3'd0, kom[1][0], 1'b0} + 12'(kom[2][0]));
    gy  = (12'(kom[2][0]) + {3'd0, kom[2][1], 1'b0} + 12'(kom[2][2]))
        - (12'(kom[0][0]) + {3'd0, kom[0][1], 1'b0} + 12'(kom[0][2]));
    ax  = gx[11] ? (12'd0 - gx) : gx;
    ay  = gy[11] ? (12'd0 - gy) : gy;
    axy = ax + ay;
`ifdef GORB_BULANIK_EN
    bul = 12'(kom[0][0]) + {3'd0, kom[0][1], 1'b0} + 12'(kom[0][2])
        + {3'd0, kom[1][0], 1'b0} + {2'd0, kom[1][1], 2'b0} + {3'd0, kom[1][2], 1'b0}
        + 12'(kom[2][0]) + {3'd0, kom[2][1], 1'b0} + 12'(kom[2][2]);
`endif
    case (gorev_q)
      GRV1_G_SX:  sonuc = doyur(ax);
      GRV1_G_SY:  sonuc = doyur(ay);
      GRV1_G_SXY: sonuc = doyur(axy);
      GRV1_BULANIK: begin
`ifdef GORB_BULANIK_EN
        sonuc = bul[11:4];
`else
        sonuc = kom[1][1];
`endif
      end
      default:    sonuc = kom[1][1];
    endcase
  end

  always_comb begin
    durum_d = durum_q;
    satir_d = satir_q;
    sutun_d = sutun_q;
    gorev_d = gorev_q;
    etkin_d = 1'b0;
    pixel_d = pixel_q;
    if (basla) begin
      durum_d = CALIS;
      satir_d = '0;
      sutun_d = '0;
      gorev_d = gorev_i;
    end else if (kabul) begin
      if (sutun_q == SON_SUTUN) begin
        sutun_d = '0;
        satir_d = satir_q + RW'(1);
      end else begin
        sutun_d = sutun_q + CW'(1);
      end
      if (durum_q == CALIS && satir_q == SON_SATIR && sutun_q == SON_SUTUN) durum_d = BOSALT;
      if (durum_q == BOSALT && satir_q == SATIR_H1 && sutun0) begin
        durum_d = BOS;
        satir_d = '0;
        sutun_d = '0;
      end
      if (cikis_var) begin
        etkin_d = 1'b1;
        pixel_d = sonuc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q <= BOS;
      satir_q <= '0;
      sutun_q <= '0;
      gorev_q <= GRV1_GECIR;
      etkin_q <= 1'b0;
      pixel_q <= 8'd0;
    end else begin
      durum_q <= durum_d;
      satir_q <= satir_d;
      sutun_q <= sutun_d;
      gorev_q <= gorev_d;
      etkin_q <= etkin_d;
      pixel_q <= pixel_d;
    end
  end

  // Line buffers and window hold no reset: stale rows are always masked as padding.
  always_ff @(posedge clk_i) begin
    if (kabul) begin
      hat0[sutun_q] <= hat1[sutun_q];
      hat1[sutun_q] <= giris;
      for (int r = 0; r < 3; r++) begin
        pen_q[r][0] <= pen_q[r][1];
        pen_q[r][1] <= pen_q[r][2];
        pen_q[r][2] <= yeni[r];
      end
    end
  end

  assign etkin_o = etkin_q;
  assign pixel_o = pixel_q;
  assign durum_o = durum_q;
endmodule

// File: tb/tb_gorev_birimi_cekirdek.sv
// tb_gorev_birimi_cekirdek: random-stimulus bench with an image-level reference model and expected-pixel queue.
module tb_gorev_birimi_cekirdek;
  localparam int W = 20;
  localparam int H = 10;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rstn_i, basla, etkin_i;
  logic [7:0] pixel_i;
  logic [2:0] gorev_i;
  logic       etkin_o;
  logic [7:0] pixel_o;
  logic [1:0] durum_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_cyc = 0;
  int first_cyc = 0;
  int out_cnt = 0;
  int img [N];
  logic [7:0] exp_q [$];

  gorev_birimi_cekirdek #(.GENISLIK(W), .YUKSEKLIK(H)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .basla(basla), .etkin_i(etkin_i), .pixel_i(pixel_i),
    .gorev_i(gorev_i), .etkin_o(etkin_o), .pixel_o(pixel_o), .durum_o(durum_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: image-level arithmetic with zero padding
  function automatic int pxv(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r * W + c];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_pix(input int t, input int r, input int c);
    int gx, gy, v;
    gx = (pxv(r-1, c+1) + 2*pxv(r, c+1) + pxv(r+1, c+1)) - (pxv(r-1, c-1) + 2*pxv(r, c-1) + pxv(r+1, c-1));
    gy = (pxv(r+1, c-1) + 2*pxv(r+1, c) + pxv(r+1, c+1)) - (pxv(r-1, c-1) + 2*pxv(r-1, c) + pxv(r-1, c+1));
    case (t)
      1: v = iabs(gx);
      2: v = iabs(gy);
      3: v = iabs(gx) + iabs(gy);
`ifdef GORB_BULANIK_EN
      4: v = (pxv(r-1, c-1) + 2*pxv(r-1, c) + pxv(r-1, c+1) + 2*pxv(r, c-1) + 4*pxv(r, c)
            + 2*pxv(r, c+1) + pxv(r+1, c-1) + 2*pxv(r+1, c) + pxv(r+1, c+1)) / 16;
`endif
      default: v = pxv(r, c);
    endcase
    return (v > 255) ? 255 : v;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (etkin_o === 1'b1) begin
      if (out_cnt == 0) first_cyc = cyc;
      out_cnt++;
      chk("exp_avail", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("pix", pixel_o, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic push_exp(input int t, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back(8'(ref_pix(t, k / W, k % W)));
  endtask

  task automatic start_frame(input int t);
    @(negedge clk);
    basla   = 1'b1;
    gorev_i = 3'(t);
    etkin_i = 1'($urandom_range(0, 1));
    pixel_i = 8'($urandom);
    @(negedge clk);
    basla = 1'b0;
    b_cyc = cyc;
    chk("basla_vo", etkin_o, 0);
  endtask

  task automatic feed(input int cnt, input bit gaps);
    int n = 0;
    while (n < cnt) begin
      etkin_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pixel_i = etkin_i ? 8'(img[n]) : 8'($urandom);
      @(negedge clk);
      if (etkin_i) n++;
    end
    etkin_i = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() > 0 && i < W + 50) begin
      etkin_i = 1'($urandom_range(0, 1));
      pixel_i = 8'($urandom);
      @(negedge clk);
      i++;
    end
    repeat (6) begin
      etkin_i = 1'($urandom_range(0, 1));
      pixel_i = 8'($urandom);
      @(negedge clk);
    end
    etkin_i = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int t, input bit gaps);
    push_exp(t, N);
    out_cnt = 0;
    start_frame(t);
    feed(N, gaps);
    drain();
    chk("count", out_cnt, N);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) img[k] = k % 256;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) img[k] = $urandom_range(0, 255);
  endtask

  initial begin
    rstn_i = 1'b0; basla = 1'b0; etkin_i = 1'b0; pixel_i = 8'd0; gorev_i = 3'd0;
    #12;
    chk("rst_vo", etkin_o, 0);
    chk("rst_po", pixel_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (10) begin
      etkin_i = 1'b1;
      pixel_i = 8'($urandom);
      @(negedge clk);
    end
    etkin_i = 1'b0;

    fill_ramp();
    run_frame(0, 1'b0);
    chk("latency", first_cyc - b_cyc, W + 2);

    for (int k = 0; k < N; k++) img[k] = 100;
    run_frame(3, 1'b0);

    for (int k = 0; k < N; k++) img[k] = 0;
    img[5 * W + 10] = 255;
    run_frame(1, 1'b0);

    fill_ramp();
    run_frame(2, 1'b1);

    for (int t = 0; t < 8; t++) begin
      fill_rand();
      run_frame(t, 1'b1);
    end

    // abort after 120 inputs, then a full frame with another task
    fill_ramp();
    push_exp(0, 120 - W - 1);
    out_cnt = 0;
    start_frame(0);
    feed(120, 1'b0);
    start_frame(3);
    chk("abort_left", exp_q.size(), 0);
    chk("abort_cnt", out_cnt, 120 - W - 1);
    fill_rand();
    push_exp(3, N);
    out_cnt = 0;
    feed(N, 1'b1);
    drain();
    chk("count_after_abort", out_cnt, N);

    // asynchronous reset mid-frame
    fill_ramp();
    push_exp(0, N);
    out_cnt = 0;
    start_frame(0);
    feed(80, 1'b0);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_vo", etkin_o, 0);
    chk("arst_po", pixel_o, 0);
    exp_q.delete();
    etkin_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;
    out_cnt = 0;
    repeat (30) begin
      etkin_i = 1'b1;
      pixel_i = 8'($urandom);
      @(negedge clk);
    end
    etkin_i = 1'b0;
    chk("idle_after_rst", out_cnt, 0);

    fill_rand();
    run_frame(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
